ram_72x4: RTL and testbench

RAM_72X4 -- requirements
Module: ram_72x4

---
 rtl/ram_72x4_pkg.sv | 13 +
 rtl/ram_72x4_word.sv | 44 ++++
 rtl/ram_72x4.sv | 103 ++++++++++
 tb/tb_ram_72x4.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ram_72x4_pkg.sv
// ram_72x4_pkg: shared constants and the storage word type for the
// 4 x 72-bit flip-flop RAM.
//   DATA_W_DEF - default word width
//   DEPTH_DEF  - default number of words
//   ADDR_W_DEF - default address width
//   word_t     - one storage word at the default width
package ram_72x4_pkg;
   localparam int DATA_W_DEF = 72;
   localparam int DEPTH_DEF  = 4;
   localparam int ADDR_W_DEF = 2;

   typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/ram_72x4_word.sv
// ram_72x4_word: one flip-flop storage word with synchronous clear.
// Optional macro RAM_72X4_PARITY_EN adds one stored even-parity bit.
//   clk  - rising-edge clock
//   rst  - synchronous active-high clear of the word (and parity bit)
//   we   - write enable, loads d on the rising edge
//   d    - write data
//   q    - stored word
//   p    - stored even parity of the last written d (parity build only)
module ram_72x4_word
   import ram_72x4_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
`ifdef RAM_72X4_PARITY_EN
   ,
   output logic              p
`endif
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

`ifdef RAM_72X4_PARITY_EN
   // Even parity: p makes the total count of ones in {q, p} even.
   always_ff @(posedge clk) begin
      if (rst) begin
         p <= 1'b0;
      end else if (we) begin
         p <= ^d;
      end
   end
`endif

endmodule

// File: rtl/ram_72x4.sv
// ram_72x4: single-port DEPTH x DATA_W RAM built from flip-flops.
// The read data is registered, so a read returns data one cycle after its edge.
// Optional macro RAM_72X4_PARITY_EN adds per-word parity and a parity_err output.
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset; it overrides any access
//   en         - active-low chip enable
//   wr         - active-low write strobe (0 = write, 1 = read) when en = 0
//   address    - word select
//   data_in    - write data
//   data_out   - registered read data; it holds when no read occurs
//   parity_err - registered read parity mismatch (parity build only)
module ram_72x4
   import ram_72x4_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              wr,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
`ifdef RAM_72X4_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   logic              wr_sel;
   logic              rd_sel;
   logic [DEPTH-1:0]  we;
   logic [DATA_W-1:0] q_arr [DEPTH];
   logic [DATA_W-1:0] rd_word;
`ifdef RAM_72X4_PARITY_EN
   logic [DEPTH-1:0]  p_arr;
   logic              rd_par;
`endif

   assign wr_sel = !en && !wr;
   assign rd_sel = !en && wr;

   always_comb begin
      we = '0;
      for (int i = 0; i < DEPTH; i++) begin
         we[i] = wr_sel && (address == ADDR_W'(i));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      ram_72x4_word #(
         .DATA_W (DATA_W)
      ) u_word (
         .clk (clk),
         .rst (rst),
         .we  (we[g]),
         .d   (data_in),
         .q   (q_arr[g])
`ifdef RAM_72X4_PARITY_EN
         ,
         .p   (p_arr[g])
`endif
      );
   end

   // The mux uses a full compare, so an address value with no word
   // behind it reads as zero and never aliases onto another word.
   always_comb begin
      rd_word = '0;
`ifdef RAM_72X4_PARITY_EN
      rd_par  = 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         if (address == ADDR_W'(i)) begin
            rd_word = q_arr[i];
`ifdef RAM_72X4_PARITY_EN
            rd_par  = p_arr[i];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
      end else if (rd_sel) begin
         data_out <= rd_word;
      end
   end

`ifdef RAM_72X4_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else if (rd_sel) begin
         parity_err <= (^rd_word) ^ rd_par;
      end
   end
`endif

endmodule

// File: tb/tb_ram_72x4.sv
// tb_ram_72x4: scoreboard bench for ram_72x4. The driver updates an array
// model of the RAM and queues the expected data_out (and parity_err) for
// every clock edge. A separate monitor pops one entry after each edge and
// compares it with the DUT outputs.
module tb_ram_72x4;
   import ram_72x4_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       wr = 1'b1;
   logic [1:0] address = '0;
   word_t      data_in = '0;
   word_t      data_out;
`ifdef RAM_72X4_PARITY_EN
   logic       parity_err;
`endif

   ram_72x4 dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .wr       (wr),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out)
`ifdef RAM_72X4_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      word_t data;
      logic  perr;
      int    tag;
   } exp_t;

   exp_t  exp_q[$];
   word_t mem_m [4];
   logic  bad_m [4];
   word_t out_m = '0;
   logic  perr_m = 1'b0;
   int    n_tests = 0;
   int    n_fail = 0;

   localparam word_t W_A = 72'h12_3456_789A_BCDE_F012;

   // Apply one cycle of inputs at the falling edge, then update the model and
   // queue the outputs that are expected after the next rising edge.
   task automatic cyc(input logic r, input logic e, input logic w,
                      input logic [1:0] a, input word_t d, input int tag);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; wr = w; address = a; data_in = d;
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            mem_m[i] = '0;
            bad_m[i] = 1'b0;
         end
         out_m  = '0;
         perr_m = 1'b0;
      end else if (!e) begin
         if (!w) begin
            mem_m[a] = d;
            bad_m[a] = 1'b0;
         end else begin
            out_m  = mem_m[a];
            perr_m = bad_m[a];
         end
      end
      x.data = out_m;
      x.perr = perr_m;
      x.tag  = tag;
      exp_q.push_back(x);
   endtask

   task automatic wr_word(input logic [1:0] a, input word_t d, input int tag);
      cyc(1'b0, 1'b0, 1'b0, a, d, tag);
   endtask

   task automatic rd_word(input logic [1:0] a, input int tag);
      cyc(1'b0, 1'b0, 1'b1, a, '0, tag);
   endtask

   // Monitor: one expectation per rising edge, checked 1 time unit later.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_tests++;
            if (data_out !== x.data) begin
               n_fail++;
               $display("FAIL data_out tag=%0d got=%h expected=%h", x.tag, data_out, x.data);
            end
`ifdef RAM_72X4_PARITY_EN
            n_tests++;
            if (parity_err !== x.perr) begin
               n_fail++;
               $display("FAIL parity_err tag=%0d got=%b expected=%b", x.tag, parity_err, x.perr);
            end
`endif
         end
      end
   end

   initial begin
      word_t vals [4];
      logic  r, e, w;
      vals[0] = 72'hAA_AAAA_AAAA_AAAA_AAA0;
      vals[1] = 72'h55_5555_5555_5555_5551;
      vals[2] = 72'hFF_FFFF_FFFF_FFFF_FFF2;
      vals[3] = 72'h00_0000_0000_0000_0003;

      // Reset, then every address reads zero.
      cyc(1'b1, 1'b1, 1'b1, 2'd0, '0, 1);
      for (int i = 0; i < 4; i++) rd_word(2'(i), 2);

      // Single write and read-back.
      wr_word(2'd0, W_A, 3);
      rd_word(2'd0, 4);

      // Distinct words, read back in reverse order.
      for (int i = 0; i < 4; i++) wr_word(2'(i), vals[i], 5);
      for (int i = 3; i >= 0; i--) rd_word(2'(i), 6);

      // Chip disabled: a write strobe with zero data must be ignored.
      rd_word(2'd0, 7);
      wr_word(2'd0, W_A, 7);
      rd_word(2'd0, 7);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 2'd0, '0, 8);
      cyc(1'b0, 1'b1, 1'b1, 2'd2, '0, 8);
      rd_word(2'd0, 9);

      // Reset together with a write: the write is lost and all words clear.
      cyc(1'b1, 1'b0, 1'b0, 2'd1, 72'hFF_FFFF_FFFF_FFFF_FFFF, 10);
      for (int i = 0; i < 4; i++) rd_word(2'(i), 11);

      // Reset in the middle of a sequence.
      wr_word(2'd3, W_A, 12);
      rd_word(2'd3, 12);
      cyc(1'b1, 1'b0, 1'b1, 2'd3, '0, 13);
      rd_word(2'd3, 14);

`ifdef RAM_72X4_PARITY_EN
      // Corrupt one stored bit of address 1 and check the read parity flag.
      wr_word(2'd1, W_A, 15);
      wr_word(2'd0, vals[0], 15);
      force dut.g_word[1].u_word.q = W_A ^ 72'h1;
      mem_m[1] = W_A ^ 72'h1;
      bad_m[1] = 1'b1;
      rd_word(2'd1, 16);
      rd_word(2'd0, 17);
      release dut.g_word[1].u_word.q;
      cyc(1'b0, 1'b1, 1'b1, 2'd1, '0, 18);
      wr_word(2'd1, W_A, 19);
      rd_word(2'd1, 19);
`endif

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         r = ($urandom_range(0, 39) == 0);
         e = ($urandom_range(0, 4) == 0);
         w = 1'($urandom_range(0, 1));
         cyc(r, e, w, 2'($urandom_range(0, 3)),
             word_t'({$urandom(), $urandom(), $urandom()}), 100);
      end
      cyc(1'b0, 1'b1, 1'b1, 2'd0, '0, 101);

      repeat (3) @(posedge clk);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got=%0d expected=0 entries left", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
